// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
package sram_arb_pkg;

    localparam int AW_DEFAULT = 20;
    localparam int DW_DEFAULT = 16;

    localparam int DISP = 0;
    localparam int LOAD = 1;
    localparam int COMP = 2;

    typedef enum logic [2:0] {
        ARB,
        READ,
        WSETUP,
        WPULSE,
        WHOLD
    } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin pick between loader (bit0) and compute (bit1).
module sram_arb_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] pick
);

    logic last_comp;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_comp ? 2'b01 : 2'b10;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_comp <= 1'b1;
        end else if (advance && (pick != 2'b00)) begin
            last_comp <= pick[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates display, loader and compute requesters onto one asynchronous SRAM.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*AW-1:0]     addr,
    input  logic [3*(DW/8)-1:0] be,
    input  logic [3*DW-1:0]     wdata,
    output logic [2:0]          gnt,
    output logic [DW-1:0]       rdata,
    output logic [2:0]          rvalid,
    output logic                busy,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [DW-1:0]       sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam int BW = DW / 8;

    state_t          state, next_state;
    logic [1:0]      rr_pick;
    logic            rr_advance;
    logic [2:0]      win;
    logic            win_write;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic [2:0]      owner_q;

    sram_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req[COMP:LOAD]),
        .advance (rr_advance),
        .pick    (rr_pick)
    );

    // Display preempts the loader/compute rotation outright.
    always_comb begin
        win = {rr_pick, 1'b0};
        if (req[DISP]) begin
            win = 3'b001;
        end
        win_write  = |(we & win & 3'b110);
        rr_advance = (state == ARB) && !req[DISP];
        gnt        = (state == ARB) ? win : 3'b000;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB:     if (win != 3'b000) next_state = win_write ? WSETUP : READ;
            READ:    next_state = ARB;
            WSETUP:  next_state = WPULSE;
            WPULSE:  next_state = WHOLD;
            WHOLD:   next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: datapath registers are reset too, so the pads present a defined address/data during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            owner_q <= '0;
            rdata   <= '0;
            rvalid  <= '0;
        end else begin
            rvalid <= (state == READ) ? owner_q : 3'b000;
            if (state == READ) begin
                rdata <= sram_dq_i;
            end
            if (state == ARB && win != 3'b000) begin
                owner_q <= win;
                for (int i = 0; i < 3; i++) begin
                    if (win[i]) begin
                        addr_q  <= addr[i*AW +: AW];
                        wdata_q <= wdata[i*DW +: DW];
                        be_q    <= be[i*BW +: BW];
                    end
                end
            end
        end
    end

    // Strobes decode straight from the state register so reset releases the bus immediately.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            READ: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            WSETUP, WPULSE, WHOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_ub_n  = ~be_q[BW-1];
                sram_lb_n  = ~be_q[0];
                sram_we_n  = (state != WPULSE);
            end
            default: ;
        endcase
    end

    assign busy      = (state != ARB);
    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reads, writes, priority rotation and async reset.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;

    // Strobe bundle {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}
    localparam logic [5:0] S_IDLE  = 6'b111110;
    localparam logic [5:0] S_READ  = 6'b001000;
    localparam logic [5:0] S_WSET  = 6'b011101;
    localparam logic [5:0] S_WPUL  = 6'b010101;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2:0]          req = '0;
    logic [2:0]          we = '0;
    logic [3*AW-1:0]     addr = '0;
    logic [3*BW-1:0]     be = '0;
    logic [3*DW-1:0]     wdata = '0;
    logic [2:0]          gnt;
    logic [DW-1:0]       rdata;
    logic [2:0]          rvalid;
    logic                busy;
    logic [AW-1:0]       sram_addr;
    logic [DW-1:0]       sram_dq_o;
    logic                sram_dq_oe;
    logic [DW-1:0]       sram_dq_i = '0;
    logic                sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [5:0]          strb;

    int total = 0;
    int bad = 0;

    assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe};

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .be         (be),
        .wdata      (wdata),
        .gnt        (gnt),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    always #10 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #5;
        total++; if (strb !== S_IDLE) begin bad++; $display("FAIL rst_strobes got=%b exp=%b", strb, S_IDLE); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rst_rvalid got=%b exp=000", rvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
        total++; if (sram_addr !== 20'h00000) begin bad++; $display("FAIL rst_addr got=%h exp=00000", sram_addr); end
        total++; if (sram_dq_o !== 16'h0000) begin bad++; $display("FAIL rst_dq_o got=%h exp=0000", sram_dq_o); end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [5];
        int n;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
        n = 0;
        cyc();
        req = 3'b111;
        we  = 3'b000;
        for (int c = 0; c < 40 && n < 5; c++) begin
            smp();
            if (n > 0 && rvalid != 3'b000) begin
                total++;
                if (rvalid !== exp_g[n-1]) begin bad++; $display("FAIL rr_rvalid%0d got=%b exp=%b", n-1, rvalid, exp_g[n-1]); end
            end
            if (gnt != 3'b000) begin
                total++;
                if (gnt !== exp_g[n]) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt, exp_g[n]); end
                n++;
            end
            cyc();
            if (n >= 1) req[DISP] = 1'b0;
            if (n == 5) req = 3'b000;
        end
        total++; if (n != 5) begin bad++; $display("FAIL rr_timeout got=%0d grants exp=5", n); end
        cyc();
        smp();
        total++; if (rvalid !== 3'b100) begin bad++; $display("FAIL rr_last_rvalid got=%b exp=100", rvalid); end
    endtask

    task automatic test_display_read();
        cyc();
        req = 3'b001;
        we  = 3'b000;
        addr[0 +: AW] = 20'h00A05;
        sram_dq_i = 16'h00FF;
        smp();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rd_gnt got=%b exp=001", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_t got=%b exp=0", busy); end
        cyc();
        req = 3'b000;
        smp();
        total++; if (strb !== S_READ) begin bad++; $display("FAIL rd_strobes got=%b exp=%b", strb, S_READ); end
        total++; if (sram_addr !== 20'h00A05) begin bad++; $display("FAIL rd_addr got=%h exp=00a05", sram_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy_t1 got=%b exp=1", busy); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rd_rvalid_t1 got=%b exp=000", rvalid); end
        cyc();
        smp();
        total++; if (rvalid !== 3'b001) begin bad++; $display("FAIL rd_rvalid got=%b exp=001", rvalid); end
        total++; if (rdata !== 16'h00FF) begin bad++; $display("FAIL rd_rdata got=%h exp=00ff", rdata); end
        total++; if (strb !== S_IDLE) begin bad++; $display("FAIL rd_idle got=%b exp=%b", strb, S_IDLE); end
    endtask

    task automatic test_loader_write();
        cyc();
        req = 3'b010;
        we  = 3'b010;
        addr[AW +: AW]  = 20'h12345;
        wdata[DW +: DW] = 16'h00AB;
        be[BW +: BW]    = 2'b01;
        smp();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL wr_gnt got=%b exp=010", gnt); end
        cyc();
        req = 3'b000;
        we  = 3'b000;
        addr[AW +: AW]  = 20'h00000;
        wdata[DW +: DW] = 16'h0000;
        smp();
        total++; if (strb !== S_WSET) begin bad++; $display("FAIL wr_strobes_t1 got=%b exp=%b", strb, S_WSET); end
        total++; if (sram_addr !== 20'h12345) begin bad++; $display("FAIL wr_addr_t1 got=%h exp=12345", sram_addr); end
        total++; if (sram_dq_o !== 16'h00AB) begin bad++; $display("FAIL wr_dq_t1 got=%h exp=00ab", sram_dq_o); end
        cyc();
        smp();
        total++; if (strb !== S_WPUL) begin bad++; $display("FAIL wr_strobes_t2 got=%b exp=%b", strb, S_WPUL); end
        total++; if (sram_addr !== 20'h12345) begin bad++; $display("FAIL wr_addr_t2 got=%h exp=12345", sram_addr); end
        cyc();
        smp();
        total++; if (strb !== S_WSET) begin bad++; $display("FAIL wr_strobes_t3 got=%b exp=%b", strb, S_WSET); end
        total++; if (sram_addr !== 20'h12345) begin bad++; $display("FAIL wr_addr_t3 got=%h exp=12345", sram_addr); end
        total++; if (sram_dq_o !== 16'h00AB) begin bad++; $display("FAIL wr_dq_t3 got=%h exp=00ab", sram_dq_o); end
        cyc();
        smp();
        total++; if (strb !== S_IDLE) begin bad++; $display("FAIL wr_idle got=%b exp=%b", strb, S_IDLE); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=000", rvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_t4 got=%b exp=0", busy); end
    endtask

    task automatic test_display_we();
        cyc();
        req = 3'b001;
        we  = 3'b001;
        addr[0 +: AW] = 20'hFFFFF;
        sram_dq_i = 16'hBEEF;
        smp();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL dwe_gnt got=%b exp=001", gnt); end
        cyc();
        req = 3'b000;
        we  = 3'b000;
        smp();
        total++; if (strb !== S_READ) begin bad++; $display("FAIL dwe_strobes got=%b exp=%b", strb, S_READ); end
        total++; if (sram_addr !== 20'hFFFFF) begin bad++; $display("FAIL dwe_addr got=%h exp=fffff", sram_addr); end
        cyc();
        smp();
        total++; if (rvalid !== 3'b001) begin bad++; $display("FAIL dwe_rvalid got=%b exp=001", rvalid); end
        total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL dwe_rdata got=%h exp=beef", rdata); end
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL dwe_we_n got=%b exp=1", sram_we_n); end
    endtask

    task automatic test_reset_wpulse();
        cyc();
        req = 3'b010;
        we  = 3'b010;
        addr[AW +: AW]  = 20'h0ABCD;
        wdata[DW +: DW] = 16'h1234;
        be[BW +: BW]    = 2'b11;
        smp();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rwp_gnt got=%b exp=010", gnt); end
        cyc();
        req = 3'b000;
        we  = 3'b000;
        cyc();
        smp();
        total++; if (sram_we_n !== 1'b0) begin bad++; $display("FAIL rwp_pulse got=%b exp=0", sram_we_n); end
        #2 rst = 1'b0;
        #1;
        total++; if (strb !== S_IDLE) begin bad++; $display("FAIL rwp_strobes got=%b exp=%b", strb, S_IDLE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rwp_busy got=%b exp=0", busy); end
        total++; if (sram_addr !== 20'h00000) begin bad++; $display("FAIL rwp_addr got=%h exp=00000", sram_addr); end
        total++; if (sram_dq_o !== 16'h0000) begin bad++; $display("FAIL rwp_dq_o got=%h exp=0000", sram_dq_o); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL rwp_rdata got=%h exp=0000", rdata); end
        cyc();
        rst = 1'b1;
        req = 3'b110;
        we  = 3'b000;
        smp();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rwp_first_gnt got=%b exp=010", gnt); end
        cyc();
        req = 3'b000;
        cyc();
        smp();
        total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL rwp_rvalid got=%b exp=010", rvalid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_display_read();
        test_loader_write();
        test_display_we();
        test_reset_wpulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DW, default 16, SRAM data width.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  3  per-requester access request; bit0 display, bit1 loader, bit2 compute.
REQ-006 SHALL have port we  input  3  per-requester write flag (1 = write); bit0 ignored.
REQ-007 SHALL have port addr  input  3*AW  packed addresses, requester i at [i*AW +: AW].
REQ-008 SHALL have port be  input  3*(DW/8)  packed active-high byte enables for writes.
REQ-009 SHALL have port wdata  input  3*DW  packed write data.
REQ-010 SHALL have port gnt  output  3  one-cycle grant pulse, one-hot or zero.
REQ-011 SHALL have port rdata  output  DW  read data, broadcast to all requesters.
REQ-012 SHALL have port rvalid  output  3  one-cycle pulse marking rdata valid for the owning requester.
REQ-013 SHALL have port busy  output  1  high whenever a transaction is in flight (state != ARB).
REQ-014 SHALL have port sram_addr  output  AW  registered SRAM address.
REQ-015 SHALL have port sram_dq_o  output  DW  write data to pad.
REQ-016 SHALL have port sram_dq_oe  output  1  pad output enable.
REQ-017 SHALL have port sram_dq_i  input  DW  read data from pad.
REQ-018 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-019 SHALL have ports sram_ub_n, sram_lb_n  output  1 each  active-low byte-lane selects.

Function
REQ-020 SHALL implement FSM states ARB, READ, WSETUP, WPULSE, WHOLD; each lasts one clk.
REQ-021 In ARB, SHALL pick a winner among asserted req bits, pulse its gnt, and capture its addr/we/be/wdata on that edge; no req -> stay in ARB, gnt=0.
REQ-022 Priority: display (bit0) strictly highest; loader and compute round-robin on last-granted pointer; no starvation guard for bits 1/2.
REQ-023 Requester SHALL hold req/addr/we/be/wdata stable until its gnt; req held after gnt counts as a new request.
REQ-024 Read: ARB(t, gnt) -> READ(t+1: ce_n=0, oe_n=0, we_n=1, ub_n=lb_n=0) -> rdata registered from sram_dq_i at end of t+1, rvalid pulse during t+2 (next ARB); max one read per 2 clk.
REQ-025 Write: ARB(t) -> WSETUP(t+1: ce_n=0, dq_oe=1) -> WPULSE(t+2: we_n=0) -> WHOLD(t+3: we_n=1, ce_n=0, dq_oe=1) -> ARB(t+4); oe_n=1 throughout; no rvalid.
REQ-026 sram_addr, sram_dq_o, ub_n/lb_n SHALL be constant from t+1 to end of transaction; ub_n/lb_n = ~be for writes.
REQ-027 Display we bit SHALL be ignored; display accesses are always reads.
REQ-028 In ARB with no transaction, SHALL drive ce_n=1, oe_n=1, we_n=1, ub_n=lb_n=1, dq_oe=0.
REQ-029 sram_dq_oe and sram_oe_n SHALL never be simultaneously active.
REQ-030 sram_addr wrap: full AW range accepted as-is, no bounds check.

Reset
REQ-031 On rst low (any state, including WPULSE) SHALL immediately force ARB, gnt=0, rvalid=0, rdata=0, busy=0, sram_addr=0, dq_o=0, dq_oe=0, all strobes and lane selects 1; in-flight transaction dropped without rvalid.
REQ-032 Round-robin pointer SHALL reset to "compute last", so loader wins the first tie.

Structure
REQ-033 Shared package sram_arb_pkg SHALL hold the FSM state enum, requester index constants (DISP=0, LOAD=1, COMP=2) and AW/DW defaults.
REQ-034 Two-way round-robin selector SHALL be one sub-module, sram_arb_rr (req pair, advance strobe -> one-hot pick).

Verification
REQ-035 Display read addr 0x00A05, sram_dq_i=0x00FF -> gnt=001 at t, ce_n/oe_n low at t+1, rvalid=001 and rdata=0x00FF at t+2.
REQ-036 Loader write addr 0x12345, wdata 0x00AB, be=01 -> we_n low only at t+2, lb_n=0, ub_n=1, dq_oe high t+1..t+3, addr stable t+1..t+3.
REQ-037 req=111 held, display dropped after first gnt -> grant order 001, 010, 100, 010, 100.
REQ-038 rst low during WPULSE -> we_n, ce_n =1 and dq_oe=0 without waiting for clk; after release, req=110 -> first gnt=010.
REQ-039 Display req with we[0]=1 -> READ path taken, sram_we_n never low, rvalid[0] pulses.
